enemy_wave_ctrl: RTL and testbench

Game-level scheduler for a pool of enemy instances. It decides when each enemy slot spawns and tracks hits, kill count and difficulty level. It also supplies the shared motion-timer limit that sets enemy speed. It sits between the top-level game FSM and the `N_ENEMY` enemy modules, consuming their `enemy_hit` outputs and driving their spawn/enable inputs.

---
 rtl/enemy_wave_ctrl.sv | 164 ++++++++++++++++
 tb/tb_enemy_wave_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_ctrl.sv
// Enemy wave scheduler: spawns slots on a fixed interval, counts kills, raises difficulty level.
// All outputs registered; a kill is reflected two edges after enemy_hit is first seen high.
module enemy_wave_ctrl #(
   parameter int N_ENEMY         = 4,
   parameter int SPAWN_DELAY     = 50_000_000,
   parameter int TIMER_MAX_INIT  = 4_000_000,
   parameter int TIMER_STEP      = 250_000,
   parameter int TIMER_MIN       = 1_000_000,
   parameter int KILLS_PER_LEVEL = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               game_start,
   input  logic               game_over,
   input  logic [N_ENEMY-1:0] enemy_hit,
   output logic [N_ENEMY-1:0] enemy_active,
   output logic [N_ENEMY-1:0] spawn_pulse,
   output logic [21:0]        motion_timer_max,
   output logic [3:0]         level,
   output logic [7:0]         kill_count,
   output logic               score_pulse
);

   localparam int CW = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SPAWN_DELAY - 1);
   localparam logic [22:0]   STEP_EXT  = 23'(TIMER_STEP);
   localparam logic [22:0]   MIN_EXT   = 23'(TIMER_MIN);
   localparam logic [21:0]   TMR_INIT  = 22'(TIMER_MAX_INIT);
   localparam logic [7:0]    KPL       = 8'(KILLS_PER_LEVEL);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t             state_q, state_d;
   logic [N_ENEMY-1:0] active_q, active_d;
   logic [N_ENEMY-1:0] spawn_q, spawn_d;
   logic               score_q, score_d;
   logic [3:0]         level_q, level_d;
   logic [7:0]         kills_q, kills_d;
   logic [7:0]         lvl_kills_q, lvl_kills_d;
   logic [21:0]        tmr_q, tmr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N_ENEMY-1:0] hit_q, hit_prev_q;

   logic [N_ENEMY-1:0] kill, free, spawn_sel;
   logic               found;
   logic [3:0]         kill_cnt;
   logic [8:0]         kills_sum, lvl_sum;
   logic [7:0]         kills_sat, lvl_sat;
   logic [22:0]        tmr_ext;
   logic [21:0]        tmr_dec;

   always_comb begin
      kill      = hit_q & ~hit_prev_q & active_q;
      free      = ~active_q;
      spawn_sel = '0;
      found     = 1'b0;
      kill_cnt  = '0;
      for (int i = 0; i < N_ENEMY; i++) begin
         kill_cnt = kill_cnt + 4'(kill[i]);
         if (free[i] && !found) begin
            spawn_sel[i] = 1'b1;
            found        = 1'b1;
         end
      end
      kills_sum = {1'b0, kills_q} + 9'(kill_cnt);
      lvl_sum   = {1'b0, lvl_kills_q} + 9'(kill_cnt);
      kills_sat = kills_sum[8] ? 8'hFF : kills_sum[7:0];
      lvl_sat   = lvl_sum[8] ? 8'hFF : lvl_sum[7:0];
      // 23-bit so a step larger than the current limit shows up as a borrow
      tmr_ext   = {1'b0, tmr_q} - STEP_EXT;
      tmr_dec   = (tmr_ext[22] || tmr_ext < MIN_EXT) ? MIN_EXT[21:0] : tmr_ext[21:0];
   end

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      spawn_d     = '0;
      score_d     = 1'b0;
      level_d     = level_q;
      kills_d     = kills_q;
      lvl_kills_d = lvl_kills_q;
      tmr_d       = tmr_q;
      cnt_d       = cnt_q;

      case (state_q)
         S_RUN: begin
            if (game_over) begin
               state_d = S_HALT;
            end else begin
               if (cnt_q == CNT_LAST) begin
                  if (|free) begin
                     spawn_d = spawn_sel;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
               active_d = (active_q & ~kill) | spawn_d;
               if (|kill) begin
                  score_d = 1'b1;
                  kills_d = kills_sat;
                  if (lvl_sat >= KPL) begin
                     lvl_kills_d = lvl_sat - KPL;
                     level_d     = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                     tmr_d       = tmr_dec;
                  end else begin
                     lvl_kills_d = lvl_sat;
                  end
               end
            end
         end
         default: ;
      endcase

      // Start/restart wins over everything else in any state
      if (game_start) begin
         state_d     = S_RUN;
         active_d    = '0;
         spawn_d     = '0;
         score_d     = 1'b0;
         level_d     = '0;
         kills_d     = '0;
         lvl_kills_d = '0;
         tmr_d       = TMR_INIT;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         active_q    <= '0;
         spawn_q     <= '0;
         score_q     <= 1'b0;
         level_q     <= '0;
         kills_q     <= '0;
         lvl_kills_q <= '0;
         tmr_q       <= TMR_INIT;
         cnt_q       <= '0;
         hit_q       <= '0;
         hit_prev_q  <= '0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         spawn_q     <= spawn_d;
         score_q     <= score_d;
         level_q     <= level_d;
         kills_q     <= kills_d;
         lvl_kills_q <= lvl_kills_d;
         tmr_q       <= tmr_d;
         cnt_q       <= cnt_d;
         hit_q       <= enemy_hit;
         hit_prev_q  <= hit_q;
      end
   end

   assign enemy_active     = active_q;
   assign spawn_pulse      = spawn_q;
   assign score_pulse      = score_q;
   assign level            = level_q;
   assign kill_count       = kills_q;
   assign motion_timer_max = tmr_q;

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Directed bench for enemy_wave_ctrl: spawn schedule, kills, level/timer ramp, halt, restart, reset.
module tb_enemy_wave_ctrl;

   logic        clk;
   logic        reset;
   logic        game_start;
   logic        game_over;
   logic [3:0]  enemy_hit;
   logic [3:0]  enemy_active;
   logic [3:0]  spawn_pulse;
   logic [21:0] motion_timer_max;
   logic [3:0]  level;
   logic [7:0]  kill_count;
   logic        score_pulse;

   int n_chk  = 0;
   int n_pass = 0;
   int extra;

   enemy_wave_ctrl #(
      .N_ENEMY(4), .SPAWN_DELAY(8), .TIMER_MAX_INIT(100),
      .TIMER_STEP(30), .TIMER_MIN(40), .KILLS_PER_LEVEL(2)
   ) dut (
      .clk(clk), .reset(reset), .game_start(game_start), .game_over(game_over),
      .enemy_hit(enemy_hit), .enemy_active(enemy_active), .spawn_pulse(spawn_pulse),
      .motion_timer_max(motion_timer_max), .level(level), .kill_count(kill_count),
      .score_pulse(score_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; game_start = 1'b0; game_over = 1'b0; enemy_hit = 4'b0000;
      step(2);
      chk("rst_active", 32'(enemy_active), 32'd0);
      chk("rst_spawn", 32'(spawn_pulse), 32'd0);
      chk("rst_score", 32'(score_pulse), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_kills", 32'(kill_count), 32'd0);
      chk("rst_timer", 32'(motion_timer_max), 32'd100);
      reset = 1'b0;
      step(1);

      // spawn schedule from game start
      game_start = 1'b1;
      step(1);
      game_start = 1'b0;
      step(7);
      chk("no_early_spawn", 32'(spawn_pulse), 32'd0);
      step(1);
      chk("spawn0", 32'(spawn_pulse), 32'b0001);
      chk("active0", 32'(enemy_active), 32'b0001);
      step(1);
      chk("spawn0_single", 32'(spawn_pulse), 32'd0);
      step(7);
      chk("spawn1", 32'(spawn_pulse), 32'b0010);
      step(8);
      chk("spawn2", 32'(spawn_pulse), 32'b0100);
      step(8);
      chk("spawn3", 32'(spawn_pulse), 32'b1000);
      chk("all_active", 32'(enemy_active), 32'b1111);
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (spawn_pulse != 4'b0000) extra++;
      end
      chk("no_spawn_when_full", 32'(extra), 32'd0);

      // single kill on slot 2, held high for 20 cycles
      enemy_hit = 4'b0100;
      step(1);
      chk("kill_not_yet", 32'(enemy_active), 32'b1111);
      step(1);
      chk("kill2_active", 32'(enemy_active), 32'b1011);
      chk("kill2_count", 32'(kill_count), 32'd1);
      chk("kill2_score", 32'(score_pulse), 32'd1);
      step(1);
      chk("respawn2", 32'(spawn_pulse), 32'b0100);
      chk("respawn2_active", 32'(enemy_active), 32'b1111);
      chk("score_single", 32'(score_pulse), 32'd0);
      step(17);
      chk("held_hit_once", 32'(kill_count), 32'd1);
      enemy_hit = 4'b0000;
      step(2);

      // double kill completes level 1
      enemy_hit = 4'b0011;
      step(2);
      chk("dbl_kills", 32'(kill_count), 32'd3);
      chk("dbl_active", 32'(enemy_active), 32'b1100);
      chk("dbl_score", 32'(score_pulse), 32'd1);
      chk("lvl1", 32'(level), 32'd1);
      chk("timer70", 32'(motion_timer_max), 32'd70);
      enemy_hit = 4'b0000;
      step(1);
      chk("dbl_score_single", 32'(score_pulse), 32'd0);
      chk("respawn0", 32'(spawn_pulse), 32'b0001);
      chk("respawn0_active", 32'(enemy_active), 32'b1101);
      step(8);
      chk("respawn1", 32'(spawn_pulse), 32'b0010);
      chk("refill_active", 32'(enemy_active), 32'b1111);
      step(1);
      enemy_hit = 4'b1000;
      step(2);
      chk("lvl2_kills", 32'(kill_count), 32'd4);
      chk("lvl2", 32'(level), 32'd2);
      chk("timer40", 32'(motion_timer_max), 32'd40);
      chk("lvl2_active", 32'(enemy_active), 32'b0111);
      enemy_hit = 4'b0000;
      step(1);
      enemy_hit = 4'b0111;
      step(2);
      chk("lvl3_kills", 32'(kill_count), 32'd7);
      chk("lvl3", 32'(level), 32'd3);
      chk("timer_floor", 32'(motion_timer_max), 32'd40);
      chk("lvl3_active", 32'(enemy_active), 32'b0000);

      // hit on an inactive slot
      enemy_hit = 4'b1000;
      step(2);
      chk("inactive_score", 32'(score_pulse), 32'd0);
      chk("inactive_spawn", 32'(spawn_pulse), 32'b0001);
      step(1);
      chk("inactive_kills", 32'(kill_count), 32'd7);
      enemy_hit = 4'b0000;

      // game_over coincides with a kill and a due spawn
      step(5);
      enemy_hit = 4'b0001;
      step(1);
      game_over = 1'b1;
      step(1);
      chk("halt_spawn", 32'(spawn_pulse), 32'd0);
      chk("halt_score", 32'(score_pulse), 32'd0);
      chk("halt_kills", 32'(kill_count), 32'd7);
      chk("halt_active", 32'(enemy_active), 32'b0001);
      enemy_hit = 4'b0000;
      step(3);
      chk("frozen_active", 32'(enemy_active), 32'b0001);
      chk("frozen_level", 32'(level), 32'd3);
      game_over = 1'b0;
      game_start = 1'b1;
      step(1);
      game_start = 1'b0;
      chk("restart_active", 32'(enemy_active), 32'd0);
      chk("restart_kills", 32'(kill_count), 32'd0);
      chk("restart_level", 32'(level), 32'd0);
      chk("restart_timer", 32'(motion_timer_max), 32'd100);
      step(7);
      chk("restart_no_early", 32'(spawn_pulse), 32'd0);
      step(1);
      chk("restart_spawn", 32'(spawn_pulse), 32'b0001);
      step(1);
      enemy_hit = 4'b0001;
      step(2);
      chk("pre_reset_kill", 32'(kill_count), 32'd1);
      enemy_hit = 4'b0000;

      // async reset in the middle of a cycle
      step(2);
      #2 reset = 1'b1;
      #1;
      chk("async_active", 32'(enemy_active), 32'd0);
      chk("async_kills", 32'(kill_count), 32'd0);
      chk("async_timer", 32'(motion_timer_max), 32'd100);
      step(1);
      reset = 1'b0;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (spawn_pulse != 4'b0000 || enemy_active != 4'b0000 || score_pulse) extra++;
      end
      chk("idle_after_reset", 32'(extra), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
